avalon_mem_slave: RTL and testbench
===================================

AVALON_MEM_SLAVE -- requirements
Module: avalon_mem_slave

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 64, number of 32-bit memory words (power of two, at least 4).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, extra stall cycles per transaction (0..15).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port address  input  32  byte address from the CPU bus master; bits [1:0] ignored.
REQ-006 SHALL have port read  input  1  read request, held by the master until accepted.
REQ-007 SHALL have port write  input  1  write request, held by the master until accepted.
REQ-008 SHALL have port writedata  input  32  write data.
REQ-009 SHALL have port byteenable  input  4  byte-lane write enables; bit i covers bits [8i+7:8i].
REQ-010 SHALL have port waitrequest  output  1  high while the slave is stalling the current request.
REQ-011 SHALL have port readdata  output  32  read data, valid in the cycle waitrequest is low for a read.
REQ-012 SHALL have port protocol_error  output  1  sticky flag for master protocol violations.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT and ACK.
REQ-014 SHALL compute waitrequest combinationally as (read|write) and state != ACK.
REQ-015 IDLE with read|write high SHALL capture address, the op type and writedata, then go to WAIT if WAIT_CYCLES>0, otherwise to ACK.
REQ-016 WAIT SHALL count WAIT_CYCLES cycles, then go to ACK; a request therefore sees waitrequest high for WAIT_CYCLES+1 cycles, then low for exactly 1 cycle.
REQ-017 On a read, readdata SHALL be registered on the edge entering ACK and SHALL hold that value until the next read completes.
REQ-018 On a write, the memory update SHALL occur on the edge leaving ACK, for enabled byte lanes only.
REQ-019 ACK SHALL always return to IDLE; back-to-back requests SHALL restart at IDLE with no bubble beyond that.
REQ-020 Word index SHALL be address[log2(DEPTH_WORDS)+1:2].
REQ-021 If address >= 4*DEPTH_WORDS, the transaction SHALL complete with normal timing; reads return 0 and writes are dropped.
REQ-022 If read and write are both high in IDLE, the slave SHALL perform the write only, leave readdata unchanged, and set protocol_error.
REQ-023 If read|write drops, or address changes from its captured value, while in WAIT, the slave SHALL set protocol_error and return to IDLE without any memory update.
REQ-024 protocol_error SHALL clear only on reset.

Reset
REQ-025 Reset SHALL force state IDLE, wait counter 0, readdata 0x00000000 and protocol_error 0, immediately and independent of clk.
REQ-026 During reset, waitrequest SHALL equal read|write.
REQ-027 Reset mid-transaction SHALL abort it with no memory write.
REQ-028 Memory contents SHALL NOT be affected by reset.

Structure
REQ-029 Shared package avalon_pkg SHALL hold the state enum, data width (32) and byte-lane count (4).
REQ-030 Storage SHALL be a single sub-module byte_lane_ram: DEPTH_WORDS x 32, per-lane write enable, asynchronous read.
REQ-031 FSM, counter, capture registers and error logic SHALL be in avalon_mem_slave.

Verification (WAIT_CYCLES=2, DEPTH_WORDS=64)
REQ-032 Write test: write 0x00000030 = 0x0000007B, byteenable 1111. Required: waitrequest high 3 cycles, then low 1. A following read of 0x30 SHALL give readdata 0x0000007B in its ACK cycle.
REQ-033 Byte-lane test: write 0xAABBCCDD to 0x30 with byteenable 0010. A read of 0x30 SHALL return 0x0000CC7B.
REQ-034 Out-of-range test: read 0x00000400 SHALL return 0x00000000 with normal timing. A write of 0x11111111 to 0x400 SHALL leave word 0 unchanged.
REQ-035 Simultaneous read/write test: read=write=1 to 0x34 with data 0x5 SHALL store 0x5, leave readdata unchanged and set protocol_error=1.
REQ-036 Reset test: assert reset in WAIT of a write of 0xDEADBEEF to 0x38. Word 0x38 SHALL keep its prior value, readdata=0 and protocol_error=0.
REQ-037 Dropped-request test: drop read in the second stall cycle. protocol_error SHALL become 1, and the next read of 0x30 SHALL complete normally.

Source files
------------

// File: rtl/avalon_pkg.sv
// Shared definitions for the Avalon-MM memory slave.
//
// Holds the handshake FSM state type, the data word width, the number of
// byte lanes per word and a helper that turns a word count into the
// first byte address past the end of memory.
package avalon_pkg;

  localparam int DATA_W  = 32;
  localparam int LANES   = 4;
  localparam int LANE_W  = DATA_W / LANES;
  localparam int CNT_W   = 4;

  // IDLE: waiting for a request
  // WAIT: stalling the master for WAIT_CYCLES cycles
  // ACK:  waitrequest is low for exactly one cycle
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

  // First byte address that lies outside a memory of 'depth' words.
  function automatic logic [31:0] byte_limit(input int depth);
    return 32'(depth * LANES);
  endfunction

endpackage

// File: rtl/byte_lane_ram.sv
// Word-organised RAM with per-byte-lane write enables.
//
// Ports:
//   clk    - write clock (rising edge)
//   we     - one write enable per byte lane; lane i covers bits [8i+7:8i]
//   waddr  - word index for writes
//   wdata  - write data word
//   raddr  - word index for reads
//   rdata  - read data, asynchronous (combinational from raddr)
//
// The array is never reset, so its contents survive a reset of the
// surrounding logic.
module byte_lane_ram
  import avalon_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic [LANES-1:0]  we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  // Only the enabled lanes of the addressed word are updated.
  always_ff @(posedge clk) begin
    for (int lane = 0; lane < LANES; lane++) begin
      if (we[lane]) begin
        mem[waddr][lane*LANE_W +: LANE_W] <= wdata[lane*LANE_W +: LANE_W];
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/avalon_mem_slave.sv
// Avalon-MM memory slave with a fixed number of wait states.
//
// Every request is stalled for WAIT_CYCLES+1 cycles and then acknowledged
// with waitrequest low for one cycle. Read data is registered on entry to
// ACK; writes commit to memory on the edge leaving ACK. Accesses beyond
// the end of memory complete with normal timing but read 0 and drop
// writes. Master protocol violations (read and write together, or a
// request that drops or moves while stalled) set a sticky error flag.
//
// Ports:
//   clk            - clock, all state updates on the rising edge
//   reset          - asynchronous active-high reset
//   address        - byte address; bits [1:0] ignored for indexing
//   read, write    - request strobes, held by the master until accepted
//   writedata      - write data word
//   byteenable     - per-lane write enables
//   waitrequest    - high while the current request is stalled
//   readdata       - read data, valid in the read's acknowledge cycle
//   protocol_error - sticky master protocol violation flag
module avalon_mem_slave
  import avalon_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       address,
  input  logic              read,
  input  logic              write,
  input  logic [DATA_W-1:0] writedata,
  input  logic [LANES-1:0]  byteenable,
  output logic              waitrequest,
  output logic [DATA_W-1:0] readdata,
  output logic              protocol_error
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [31:0] ADDR_LIMIT = byte_limit(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] LAST_WAIT =
    (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

  state_t state;
  logic [CNT_W-1:0]  waitCnt;
  logic [31:0]       capAddr;
  logic [DATA_W-1:0] capData;
  logic [LANES-1:0]  capBe;
  logic              capWrite;

  logic              reqActive;
  logic [31:0]       rdAddr;
  logic              rdInRange;
  logic              capInRange;
  logic [DATA_W-1:0] ramRdata;
  logic [DATA_W-1:0] rdValue;
  logic [LANES-1:0]  ramWe;

  assign reqActive   = read | write;
  assign waitrequest = reqActive && (state != ACK);

  // With no wait states the read is sampled straight from the live bus
  // address while still in IDLE; otherwise from the captured address.
  assign rdAddr     = (state == IDLE) ? address : capAddr;
  assign rdInRange  = (rdAddr < ADDR_LIMIT);
  assign capInRange = (capAddr < ADDR_LIMIT);
  assign rdValue    = rdInRange ? ramRdata : '0;

  // Write strobes come from the registered state, so a reset that lands
  // in ACK suppresses the write along with the transaction.
  assign ramWe = (state == ACK && capWrite && capInRange) ? capBe : '0;

  byte_lane_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ramWe),
    .waddr (capAddr[AW+1:2]),
    .wdata (capData),
    .raddr (rdAddr[AW+1:2]),
    .rdata (ramRdata)
  );

  // Handshake FSM with the wait counter, capture registers, read data
  // register and sticky error flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      waitCnt        <= '0;
      capAddr        <= '0;
      capData        <= '0;
      capBe          <= '0;
      capWrite       <= 1'b0;
      readdata       <= '0;
      protocol_error <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (reqActive) begin
            capAddr  <= address;
            capData  <= writedata;
            capBe    <= byteenable;
            // A combined read+write is treated as a write only.
            capWrite <= write;
            waitCnt  <= '0;
            if (read && write) begin
              protocol_error <= 1'b1;
            end
            if (WAIT_CYCLES == 0) begin
              state <= ACK;
              if (!write) begin
                readdata <= rdValue;
              end
            end else begin
              state <= WAIT;
            end
          end
        end

        WAIT: begin
          if (!reqActive || (address != capAddr)) begin
            protocol_error <= 1'b1;
            waitCnt        <= '0;
            state          <= IDLE;
          end else if (waitCnt == LAST_WAIT) begin
            waitCnt <= '0;
            state   <= ACK;
            if (!capWrite) begin
              readdata <= rdValue;
            end
          end else begin
            waitCnt <= waitCnt + 1'b1;
          end
        end

        ACK: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_avalon_mem_slave.sv
// Directed self-checking bench for avalon_mem_slave (WAIT_CYCLES=2,
// DEPTH_WORDS=64). Each request is run through applyStimulus, which
// counts stall cycles, captures readdata in the acknowledge cycle and
// samples waitrequest one cycle later while the request is still held.
module tb_avalon_mem_slave;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        protocol_error;

  int checks = 0;
  int errors = 0;

  int          nStall;
  logic [31:0] ackData;
  logic        ackSeen;
  logic        waitNext;

  avalon_mem_slave #(
    .DEPTH_WORDS (64),
    .WAIT_CYCLES (2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .address        (address),
    .read           (read),
    .write          (write),
    .writedata      (writedata),
    .byteenable     (byteenable),
    .waitrequest    (waitrequest),
    .readdata       (readdata),
    .protocol_error (protocol_error)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called 1 time unit after a rising edge; returns at the same phase.
  task automatic applyStimulus(input logic rd, input logic wr,
                               input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] be,
                               output int stalls, output logic [31:0] rdata,
                               output logic seen, output logic waitAfter);
    read       = rd;
    write      = wr;
    address    = addr;
    writedata  = data;
    byteenable = be;
    stalls     = 0;
    rdata      = '0;
    seen       = 1'b0;
    waitAfter  = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      #1;
      if (waitrequest) begin
        stalls++;
        @(posedge clk);
        #1;
      end else begin
        seen  = 1'b1;
        rdata = readdata;
        @(posedge clk);
        #1;
        waitAfter = waitrequest;
        read  = 1'b0;
        write = 1'b0;
      end
    end
    read  = 1'b0;
    write = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    address    = '0;
    read       = 1'b0;
    write      = 1'b0;
    writedata  = '0;
    byteenable = '0;

    // Reset state and waitrequest tracking read|write during reset
    #3;
    read = 1'b1;
    #1;
    checkOutput("reset_wait_follows_req", {31'b0, waitrequest}, 32'd1);
    checkOutput("reset_readdata", readdata, 32'h0);
    checkOutput("reset_perr", {31'b0, protocol_error}, 32'd0);
    read = 1'b0;
    #1;
    checkOutput("reset_wait_idle", {31'b0, waitrequest}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(1);

    // Seed word 0 for the out-of-range aliasing check
    applyStimulus(1'b0, 1'b1, 32'h0, 32'h12345678, 4'hF, nStall, ackData, ackSeen, waitNext);
    checkOutput("seed0_ack", {31'b0, ackSeen}, 32'd1);

    // Full-word write: three stall cycles, one acknowledge cycle
    applyStimulus(1'b0, 1'b1, 32'h30, 32'h7B, 4'hF, nStall, ackData, ackSeen, waitNext);
    checkOutput("wr30_ack", {31'b0, ackSeen}, 32'd1);
    checkOutput("wr30_stalls", 32'(nStall), 32'd3);
    checkOutput("wr30_low_one_cycle", {31'b0, waitNext}, 32'd1);
    idle(1);

    applyStimulus(1'b1, 1'b0, 32'h30, 32'h0, 4'h0, nStall, ackData, ackSeen, waitNext);
    checkOutput("rd30_stalls", 32'(nStall), 32'd3);
    checkOutput("rd30_data", ackData, 32'h0000007B);
    idle(2);
    checkOutput("rd30_hold", readdata, 32'h0000007B);

    // Single byte lane write
    applyStimulus(1'b0, 1'b1, 32'h30, 32'hAABBCCDD, 4'b0010, nStall, ackData, ackSeen, waitNext);
    applyStimulus(1'b1, 1'b0, 32'h30, 32'h0, 4'h0, nStall, ackData, ackSeen, waitNext);
    checkOutput("lane1_data", ackData, 32'h0000CC7B);

    // Out-of-range read and dropped write (0x400 would alias word 0)
    applyStimulus(1'b1, 1'b0, 32'h400, 32'h0, 4'h0, nStall, ackData, ackSeen, waitNext);
    checkOutput("oor_rd_stalls", 32'(nStall), 32'd3);
    checkOutput("oor_rd_data", ackData, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h400, 32'h11111111, 4'hF, nStall, ackData, ackSeen, waitNext);
    checkOutput("oor_wr_stalls", 32'(nStall), 32'd3);
    applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, nStall, ackData, ackSeen, waitNext);
    checkOutput("word0_kept", ackData, 32'h12345678);
    checkOutput("perr_still_clear", {31'b0, protocol_error}, 32'd0);

    // Prior value for the reset-abort test
    applyStimulus(1'b0, 1'b1, 32'h38, 32'h0BADF00D, 4'hF, nStall, ackData, ackSeen, waitNext);

    // Simultaneous read and write: write wins, readdata untouched
    applyStimulus(1'b1, 1'b1, 32'h34, 32'h5, 4'hF, nStall, ackData, ackSeen, waitNext);
    checkOutput("rw_stalls", 32'(nStall), 32'd3);
    checkOutput("rw_readdata_ack", ackData, 32'h12345678);
    checkOutput("rw_readdata_after", readdata, 32'h12345678);
    checkOutput("rw_perr", {31'b0, protocol_error}, 32'd1);
    applyStimulus(1'b1, 1'b0, 32'h34, 32'h0, 4'h0, nStall, ackData, ackSeen, waitNext);
    checkOutput("rw_stored", ackData, 32'h5);

    // Reset while a write is stalled in WAIT
    address    = 32'h38;
    writedata  = 32'hDEADBEEF;
    byteenable = 4'hF;
    write      = 1'b1;
    idle(2);
    checkOutput("rst_mid_in_wait", {31'b0, waitrequest}, 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("rst_mid_readdata", readdata, 32'h0);
    checkOutput("rst_mid_perr", {31'b0, protocol_error}, 32'd0);
    checkOutput("rst_mid_wait", {31'b0, waitrequest}, 32'd1);
    write = 1'b0;
    #1;
    checkOutput("rst_mid_wait_low", {31'b0, waitrequest}, 32'd0);
    idle(2);
    reset = 1'b0;
    idle(1);
    applyStimulus(1'b1, 1'b0, 32'h38, 32'h0, 4'h0, nStall, ackData, ackSeen, waitNext);
    checkOutput("rst_word38_kept", ackData, 32'h0BADF00D);
    checkOutput("rst_perr_clear", {31'b0, protocol_error}, 32'd0);

    // Read dropped in the second stall cycle
    idle(1);
    address = 32'h30;
    read    = 1'b1;
    idle(1);
    read = 1'b0;
    idle(1);
    checkOutput("drop_perr", {31'b0, protocol_error}, 32'd1);
    checkOutput("drop_readdata", readdata, 32'h0BADF00D);
    idle(3);
    checkOutput("drop_no_ack", {31'b0, waitrequest}, 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h30, 32'h0, 4'h0, nStall, ackData, ackSeen, waitNext);
    checkOutput("drop_next_ack", {31'b0, ackSeen}, 32'd1);
    checkOutput("drop_next_stalls", 32'(nStall), 32'd3);
    checkOutput("drop_next_data", ackData, 32'h0000CC7B);
    checkOutput("perr_sticky", {31'b0, protocol_error}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
